// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// wb_write_queue: circular writeback queue merging load-unit and ALU results
// into one register-file write port; WBQ_FORWARD_EN adds pending-write bypass.
// Revision: 1.0
// ============================================================================
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_addr,
  input  logic [31:0]             mem_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_addr,
  input  logic [31:0]             alu_data,
  input  logic                    drain_en,
  output logic                    rf_write_en,
  output logic [4:0]              rf_addr_w,
  output logic [31:0]             rf_data_w,
  input  logic [4:0]              fwd_addr_a,
  input  logic [4:0]              fwd_addr_b,
  output logic                    fwd_hit_a,
  output logic                    fwd_hit_b,
  output logic [31:0]             fwd_data_a,
  output logic [31:0]             fwd_data_b,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];

  logic        full_w, empty_w;
  logic        mem_fire, alu_fire, enq, deq;
  logic [4:0]  enq_addr;
  logic [31:0] enq_data;

  always_comb begin
    full_w   = (count_q == CW'(DEPTH));
    empty_w  = (count_q == '0);
    mem_fire = mem_valid && !full_w;
    alu_fire = alu_valid && !full_w && !mem_valid;
    enq_addr = mem_fire ? mem_addr : alu_addr;
    enq_data = mem_fire ? mem_data : alu_data;
    // Writes to R0 complete the handshake but are architecturally void.
    enq      = (mem_fire || alu_fire) && (enq_addr != 5'd0);
    deq      = !empty_w && drain_en;

    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + CW'(enq) - CW'(deq);

    addr_d = addr_q;
    data_d = data_q;
    if (enq) begin
      addr_d[tail_q] = enq_addr;
      data_d[tail_q] = enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    mem_ready   = !full_w;
    alu_ready   = !full_w && !mem_valid;
    rf_write_en = deq;
    rf_addr_w   = empty_w ? 5'd0  : addr_q[head_q];
    rf_data_w   = empty_w ? 32'd0 : data_q[head_q];
    count       = count_q;
    empty       = empty_w;
    full        = full_w;
  end

`ifdef WBQ_FORWARD_EN
  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [AW-1:0] idx;
    idx        = '0;
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = 32'd0;
    fwd_data_b = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (CW'(i) < count_q) begin
        if ((fwd_addr_a != 5'd0) && (addr_q[idx] == fwd_addr_a)) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = data_q[idx];
        end
        if ((fwd_addr_b != 5'd0) && (addr_q[idx] == fwd_addr_b)) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr_a, fwd_addr_b};

  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = 32'd0;
    fwd_data_b = 32'd0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// Self-checking bench for wb_write_queue: directed scenarios plus a random
// phase, all scored against a queue model of pending writes.
module tb_wb_write_queue;

  localparam int DEPTH = 4;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_ready, alu_valid, alu_ready;
  logic [4:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, alu_data;
  logic        drain_en, rf_write_en;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w;
  logic [4:0]  fwd_addr_a, fwd_addr_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic [$clog2(DEPTH):0] count;
  logic        empty, full;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .drain_en(drain_en),
    .rf_write_en(rf_write_en), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        sb[$];
  logic [4:0]  wlog_a[$];
  logic [31:0] wlog_d[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        mon_en   = 1'b0;
  logic        mem_hold = 1'b0;
  logic        alu_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [32:0] fwd_model(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (FWD_ON && a != 5'd0)
      foreach (sb[i]) if (sb[i].a == a) r = {1'b1, sb[i].d};
    return r;
  endfunction

  // Cycle monitor: compares state before the edge, then applies the edge.
  always @(negedge clk) begin
    int          sz;
    logic        exp_mr, exp_ar, exp_we;
    logic [32:0] fa, fb;
    if (rst_n && mon_en) begin
      sz     = sb.size();
      exp_mr = (sz < DEPTH);
      exp_ar = exp_mr && !mem_valid;
      exp_we = (sz > 0) && drain_en;
      check("count", 32'(count), sz);
      check("empty", 32'(empty), 32'(sz == 0));
      check("full", 32'(full), 32'(sz == DEPTH));
      check("mem_ready", 32'(mem_ready), 32'(exp_mr));
      check("alu_ready", 32'(alu_ready), 32'(exp_ar));
      check("rf_write_en", 32'(rf_write_en), 32'(exp_we));
      if (sz > 0) begin
        check("rf_addr_w", 32'(rf_addr_w), 32'(sb[0].a));
        check("rf_data_w", rf_data_w, sb[0].d);
      end else begin
        check("rf_addr_w_empty", 32'(rf_addr_w), 32'd0);
        check("rf_data_w_empty", rf_data_w, 32'd0);
      end
      fa = fwd_model(fwd_addr_a);
      fb = fwd_model(fwd_addr_b);
      check("fwd_hit_a", 32'(fwd_hit_a), 32'(fa[32]));
      check("fwd_data_a", fwd_data_a, fa[31:0]);
      check("fwd_hit_b", 32'(fwd_hit_b), 32'(fb[32]));
      check("fwd_data_b", fwd_data_b, fb[31:0]);
      if (rf_write_en) begin
        wlog_a.push_back(rf_addr_w);
        wlog_d.push_back(rf_data_w);
      end
      if (exp_we) void'(sb.pop_front());
      if (mem_valid && exp_mr) begin
        if (mem_addr != 5'd0) sb.push_back({mem_addr, mem_data});
      end else if (alu_valid && exp_ar && alu_addr != 5'd0) begin
        sb.push_back({alu_addr, alu_data});
      end
      mem_hold = mem_valid && !exp_mr;
      alu_hold = alu_valid && !exp_ar;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int n;
    n = 0;
    idle();
    drain_en = 1'b1;
    while (count != 0 && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(count), 32'd0);
  endtask

  task automatic alu_push(input logic [4:0] a, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
    step();
    alu_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; drain_en = 1'b1; idle();
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0;
    fwd_addr_a = 5'd5; fwd_addr_b = 5'd6;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_we", 32'(rf_write_en), 32'd0);
    check("rst_addr", 32'(rf_addr_w), 32'd0);
    check("rst_data", rf_data_w, 32'd0);
    check("rst_hit_a", 32'(fwd_hit_a), 32'd0);
    check("rst_hit_b", 32'(fwd_hit_b), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1; mon_en = 1'b1;

    // Single ALU write appears on the port one cycle after acceptance.
    step();
    alu_push(5'd5, 32'h0000_00AA);
    check("t030_we", 32'(rf_write_en), 32'd1);
    check("t030_addr", 32'(rf_addr_w), 32'd5);
    check("t030_data", rf_data_w, 32'h0000_00AA);
    step();
    check("t030_count", 32'(count), 32'd0);
    check("t030_we_off", 32'(rf_write_en), 32'd0);

    // R0 write handshakes but is dropped.
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    check("t033_ready", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    check("t033_count", 32'(count), 32'd0);
    check("t033_we", 32'(rf_write_en), 32'd0);

    // Both sources valid, no drain: mem wins until full.
    drain_en = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hDEAD_0020;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_addr = 5'(10 + k); mem_data = 32'h1000 + k;
      #1;
      check("t031_alu_blocked", 32'(alu_ready), 32'd0);
      step();
    end
    check("t031_full", 32'(full), 32'd1);
    check("t031_count", 32'(count), 32'd4);
    check("t031_mem_ready", 32'(mem_ready), 32'd0);
    check("t031_alu_ready", 32'(alu_ready), 32'd0);
    drain_en = 1'b1;
    #1;
    check("t031_full_deq_ready", 32'(mem_ready), 32'd0);
    drain_all("t031_drain");

    // Youngest matching entry is forwarded.
    drain_en = 1'b0;
    alu_push(5'd3, 32'h11);
    alu_push(5'd3, 32'h22);
    fwd_addr_a = 5'd3; fwd_addr_b = 5'd0;
    #1;
    check("t032_hit_a", 32'(fwd_hit_a), 32'(FWD_ON));
    check("t032_data_a", fwd_data_a, FWD_ON ? 32'h22 : 32'h0);
    check("t032_hit_b", 32'(fwd_hit_b), 32'd0);
    fwd_addr_b = 5'd7;
    #1;
    check("t032_miss_b", 32'(fwd_hit_b), 32'd0);
    drain_all("t032_drain");

    // Asynchronous reset mid-cycle with entries pending.
    drain_en = 1'b0;
    alu_push(5'd7, 32'h77);
    alu_push(5'd8, 32'h88);
    alu_push(5'd9, 32'h99);
    drain_en = 1'b1; fwd_addr_a = 5'd8;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete(); wlog_a.delete(); wlog_d.delete();
    check("t034_count", 32'(count), 32'd0);
    check("t034_empty", 32'(empty), 32'd1);
    check("t034_we", 32'(rf_write_en), 32'd0);
    check("t034_hit", 32'(fwd_hit_a), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check("t034_no_write", 32'(rf_write_en), 32'd0);
    end
    check("t034_log", wlog_a.size(), 32'd0);

    // Ten writes through a four-entry ring with intermittent drain.
    wlog_a.delete(); wlog_d.delete();
    drain_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'h100 + 32'(i * 3);
      n = 0;
      #1;
      while (!alu_ready && n < 50) begin
        @(posedge clk); #1;
        drain_en = ~drain_en;
        #1;
        n++;
      end
      check("t035_accept", 32'(alu_ready), 32'd1);
      @(posedge clk); #1;
      drain_en = ~drain_en;
    end
    drain_all("t035_drain");
    check("t035_len", wlog_a.size(), 32'd10);
    for (int i = 0; i < 10 && i < wlog_a.size(); i++) begin
      check("t035_order_addr", 32'(wlog_a[i]), 32'(i + 1));
      check("t035_order_data", wlog_d[i], 32'h100 + 32'((i + 1) * 3));
    end

    // Random traffic; a stalled source holds its request.
    for (int c = 0; c < 400; c++) begin
      if (!mem_hold) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_addr  = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 1) == 0);
        alu_addr  = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      drain_en   = 1'($urandom_range(0, 1));
      fwd_addr_a = 5'($urandom_range(0, 7));
      fwd_addr_b = 5'($urandom_range(0, 7));
      step();
    end
    drain_all("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
